// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types, board constants and cell indexing for the move controller
package ttt_pkg;

  localparam int         BOARD_DIM  = 3;
  localparam logic [1:0] CELL_EMPTY = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  // Bit offset of cell (y,x) inside the packed 18-bit board word.
  function automatic logic [4:0] cell_idx(input logic [1:0] x, input logic [1:0] y);
    logic [4:0] lin;
    lin = 5'(y) * 5'(BOARD_DIM) + 5'(x);
    return lin << 1;
  endfunction

endpackage

// File: rtl/ttt_move_ctrl_if.sv
// rtl/ttt_move_ctrl_if.sv - board/move handshake between the move controller and the game core
interface ttt_move_ctrl_if;

  logic [17:0] board;
  logic        stop_game;
  logic        move_en;
  logic [2:0]  move_x;
  logic [2:0]  move_y;
  logic        reject;

  modport master (
    input  board,
    input  stop_game,
    output move_en,
    output move_x,
    output move_y,
    output reject
  );

  modport slave (
    output board,
    output stop_game,
    input  move_en,
    input  move_x,
    input  move_y,
    input  reject
  );

endinterface

// File: rtl/ttt_btn_debounce.sv
// rtl/ttt_btn_debounce.sv - push-button synchronizer, debouncer and rising-edge press pulse
module ttt_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          done;

  // The sample that differs from the accepted level is the last one needed.
  assign done = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level after enough consecutive differing samples; pulse only on 0->1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 != level) begin
        if (done) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ttt_move_ctrl.sv
// rtl/ttt_move_ctrl.sv - button-driven cursor and validated move issue toward the game core
module ttt_move_ctrl
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_sel,
  ttt_move_ctrl_if.master    bus,
  output logic [1:0]         cursor_x,
  output logic [1:0]         cursor_y,
  output logic               busy
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic p_up, p_down, p_left, p_right, p_sel;

  ttt_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .raw(btn_up), .press(p_up)
  );
  ttt_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .reset(reset), .raw(btn_down), .press(p_down)
  );
  ttt_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .reset(reset), .raw(btn_left), .press(p_left)
  );
  ttt_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .reset(reset), .raw(btn_right), .press(p_right)
  );
  ttt_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .reset(reset), .raw(btn_sel), .press(p_sel)
  );

  // Opposing presses in the same cycle cancel; otherwise wrap around the board edge.
  function automatic logic [1:0] step(input logic [1:0] c, input logic inc, input logic dec);
    if (inc && !dec) begin
      return (c == 2'(BOARD_DIM - 1)) ? 2'd0 : c + 2'd1;
    end else if (dec && !inc) begin
      return (c == 2'd0) ? 2'(BOARD_DIM - 1) : c - 2'd1;
    end
    return c;
  endfunction

  state_t        state;
  state_t        state_next;
  logic [1:0]    tgt_x;
  logic [1:0]    tgt_y;
  logic          latch_tgt;
  logic [SW-1:0] wait_cnt;
  logic [1:0]    tgt_cell;
  logic          move_en;
  logic [2:0]    move_x;
  logic [2:0]    move_y;
  logic          reject;

  assign tgt_cell = bus.board[cell_idx(tgt_x, tgt_y) +: 2];

  // Cursor follows debounced presses regardless of FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_x <= 2'd0;
      cursor_y <= 2'd0;
    end else begin
      cursor_x <= step(cursor_x, p_right, p_left);
      cursor_y <= step(cursor_y, p_down, p_up);
    end
  end

  // FSM state register and the target latched from the cursor at select time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      tgt_x <= 2'd0;
      tgt_y <= 2'd0;
    end else begin
      state <= state_next;
      if (latch_tgt) begin
        tgt_x <= cursor_x;
        tgt_y <= cursor_y;
      end
    end
  end

  // Settle counter runs only while in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + SW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Next-state and output decode; move coordinates read 3 except during the strobe.
  always_comb begin
    state_next = state;
    latch_tgt  = 1'b0;
    move_en    = 1'b0;
    move_x     = 3'd3;
    move_y     = 3'd3;
    reject     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (p_sel && !bus.stop_game) begin
          latch_tgt  = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bus.stop_game) begin
          state_next = ST_IDLE;
        end else if (tgt_cell == CELL_EMPTY) begin
          state_next = ST_ISSUE;
        end else begin
          reject     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        move_en    = 1'b1;
        move_x     = {1'b0, tgt_x};
        move_y     = {1'b0, tgt_y};
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == SW'(SETTLE_CYCLES - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.move_en = move_en;
  assign bus.move_x  = move_x;
  assign bus.move_y  = move_y;
  assign bus.reject  = reject;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// tb/tb_ttt_move_ctrl.sv - randomized self-checking bench for the move controller
module tb_ttt_move_ctrl;

  localparam int DB = 4;
  localparam int ST = 2;
  localparam int EN_K  = DB + 4;
  localparam int REJ_K = DB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic [1:0] cursor_x, cursor_y;
  logic       busy;

  ttt_move_ctrl_if bus ();

  ttt_move_ctrl #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .bus(bus),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mx = 0, my = 0;
  logic [1:0] model_board [3][3];

  int w_en_cnt, w_en_k, w_x, w_y, w_rej_cnt, w_rej_k, w_busy, w_viol;
  int r_en, r_mx, r_my, r_rej, r_busy, r_cx, r_cy;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] pack_board();
    logic [17:0] b;
    b = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        b[2*(3*y+x) +: 2] = model_board[y][x];
    return b;
  endfunction

  task automatic set_board_all(input logic [1:0] v);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        model_board[y][x] = v;
    bus.board = pack_board();
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    repeat (6) tick();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    repeat (10) tick();
    mx = (mx + int'(r) - int'(l) + 3) % 3;
    my = (my + int'(d) - int'(u) + 3) % 3;
  endtask

  task automatic goto_cell(input int x, input int y);
    while (mx != x) press(0, 0, 0, 1);
    while (my != y) press(0, 1, 0, 0);
  endtask

  // Drives btn_sel for one select attempt and records what the DUT did, cycle k relative to raw press.
  task automatic sel_window(input int n, input int hold, input int stop_at, input int reset_at, input bit bounce);
    int prev_en;
    prev_en = 0;
    w_en_cnt = 0; w_en_k = -1; w_x = -1; w_y = -1;
    w_rej_cnt = 0; w_rej_k = -1; w_busy = 0; w_viol = 0;
    btn_sel = bounce ? 1'b0 : 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == stop_at) bus.stop_game = 1'b1;
      if (k == reset_at) reset = 1'b1;
      @(negedge clk);
      if (bus.move_en === 1'b1) begin
        if (w_en_cnt == 0) begin
          w_en_k = k; w_x = int'(bus.move_x); w_y = int'(bus.move_y);
        end
        w_en_cnt++;
        if (prev_en != 0) w_viol++;
        if (bus.move_x >= 3 || bus.move_y >= 3) w_viol++;
      end
      prev_en = (bus.move_en === 1'b1) ? 1 : 0;
      if (bus.reject === 1'b1) begin
        if (w_rej_cnt == 0) w_rej_k = k;
        w_rej_cnt++;
      end
      if (busy === 1'b1) w_busy++;
      if (reset_at >= 0 && k == reset_at + 1) begin
        r_en = int'(bus.move_en); r_mx = int'(bus.move_x); r_my = int'(bus.move_y);
        r_rej = int'(bus.reject); r_busy = int'(busy); r_cx = int'(cursor_x); r_cy = int'(cursor_y);
      end
      tick();
      if (k == reset_at) reset = 1'b0;
      if (bounce && k + 1 < 10) btn_sel = 1'((k + 1) % 2);
      else btn_sel = (k + 1 < hold) ? 1'b1 : 1'b0;
    end
    btn_sel = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (cursor_x !== 2'd0 || cursor_y !== 2'd0) begin errors++; $display("FAIL reset_cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y); end
    checks++; if (bus.move_en !== 1'b0) begin errors++; $display("FAIL reset_move_en: got %0b expected 0", bus.move_en); end
    checks++; if (bus.move_x !== 3'd3 || bus.move_y !== 3'd3) begin errors++; $display("FAIL reset_move_xy: got (%0d,%0d) expected (3,3)", bus.move_x, bus.move_y); end
    checks++; if (bus.reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %0b expected 0", bus.reject); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tick();
    reset = 1'b0;
    mx = 0; my = 0;
    repeat (2) tick();
  endtask

  task automatic test_cursor();
    for (int i = 0; i < 4; i++) press(0, 0, 0, 1);
    for (int i = 0; i < 2; i++) press(0, 1, 0, 0);
    @(negedge clk);
    checks++; if (cursor_x !== 2'd1 || cursor_y !== 2'd2) begin errors++; $display("FAIL cursor_r4_d2: got (%0d,%0d) expected (1,2)", cursor_x, cursor_y); end
    tick();
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    @(negedge clk);
    checks++; if (cursor_x !== 2'd2) begin errors++; $display("FAIL cursor_left_wrap: got %0d expected 2", cursor_x); end
    tick();
    for (int i = 0; i < 12; i++) begin
      press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      checks++; if (int'(cursor_x) != mx || int'(cursor_y) != my) begin errors++; $display("FAIL cursor_random_%0d: got (%0d,%0d) expected (%0d,%0d)", i, cursor_x, cursor_y, mx, my); end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    int ex, ey;
    ex = mx; ey = my;
    press(1, 1, 0, 0);
    @(negedge clk);
    checks++; if (int'(cursor_y) != ey || int'(cursor_x) != ex) begin errors++; $display("FAIL simul_up_down: got (%0d,%0d) expected (%0d,%0d)", cursor_x, cursor_y, ex, ey); end
    tick();
    press(0, 0, 1, 1);
    @(negedge clk);
    checks++; if (int'(cursor_x) != ex || int'(cursor_y) != ey) begin errors++; $display("FAIL simul_left_right: got (%0d,%0d) expected (%0d,%0d)", cursor_x, cursor_y, ex, ey); end
    tick();
    press(0, 1, 0, 1);
    ex = (ex + 1) % 3; ey = (ey + 1) % 3;
    @(negedge clk);
    checks++; if (int'(cursor_x) != ex || int'(cursor_y) != ey) begin errors++; $display("FAIL simul_x_and_y: got (%0d,%0d) expected (%0d,%0d)", cursor_x, cursor_y, ex, ey); end
    tick();
  endtask

  task automatic test_move_latency();
    set_board_all(2'd2);
    goto_cell(2, 1);
    sel_window(20, 6, -1, -1, 0);
    checks++; if (w_en_cnt != 1) begin errors++; $display("FAIL latency_count: got %0d strobes expected 1", w_en_cnt); end
    checks++; if (w_en_k != EN_K) begin errors++; $display("FAIL latency_cycle: got %0d expected %0d", w_en_k, EN_K); end
    checks++; if (w_x != 2 || w_y != 1) begin errors++; $display("FAIL latency_coords: got (%0d,%0d) expected (2,1)", w_x, w_y); end
    checks++; if (w_busy != 2 + ST) begin errors++; $display("FAIL latency_busy: got %0d cycles expected %0d", w_busy, 2 + ST); end
    checks++; if (w_viol != 0 || w_rej_cnt != 0) begin errors++; $display("FAIL latency_clean: got viol %0d reject %0d expected 0 0", w_viol, w_rej_cnt); end
  endtask

  task automatic test_reject();
    set_board_all(2'd2);
    model_board[0][0] = 2'd0;
    bus.board = pack_board();
    goto_cell(0, 0);
    sel_window(20, 6, -1, -1, 0);
    checks++; if (w_rej_cnt != 1 || w_rej_k != REJ_K) begin errors++; $display("FAIL reject_pulse: got count %0d at %0d expected 1 at %0d", w_rej_cnt, w_rej_k, REJ_K); end
    checks++; if (w_en_cnt != 0) begin errors++; $display("FAIL reject_no_move: got %0d strobes expected 0", w_en_cnt); end
    checks++; if (w_busy != 1) begin errors++; $display("FAIL reject_busy: got %0d cycles expected 1", w_busy); end
  endtask

  task automatic test_random_moves();
    int tx, ty, exp_en;
    for (int i = 0; i < 10; i++) begin
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++)
          model_board[y][x] = 2'($urandom_range(0, 3));
      bus.board = pack_board();
      tx = $urandom_range(0, 2);
      ty = $urandom_range(0, 2);
      goto_cell(tx, ty);
      exp_en = (model_board[ty][tx] == 2'd2) ? 1 : 0;
      sel_window(20, 6, -1, -1, 0);
      checks++; if (w_en_cnt != exp_en || w_rej_cnt != 1 - exp_en) begin errors++; $display("FAIL random_move_%0d: got move %0d reject %0d expected move %0d reject %0d (cell %0d)", i, w_en_cnt, w_rej_cnt, exp_en, 1 - exp_en, model_board[ty][tx]); end
      if (exp_en == 1) begin
        checks++; if (w_x != tx || w_y != ty || w_en_k != EN_K) begin errors++; $display("FAIL random_coords_%0d: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", i, w_x, w_y, w_en_k, tx, ty, EN_K); end
      end else begin
        checks++; if (w_rej_k != REJ_K) begin errors++; $display("FAIL random_reject_cycle_%0d: got %0d expected %0d", i, w_rej_k, REJ_K); end
      end
      checks++; if (w_viol != 0) begin errors++; $display("FAIL random_strobe_shape_%0d: got %0d violations expected 0", i, w_viol); end
    end
  endtask

  task automatic test_bounce();
    set_board_all(2'd2);
    sel_window(40, 26, -1, -1, 1);
    checks++; if (w_en_cnt != 1) begin errors++; $display("FAIL bounce_count: got %0d strobes expected 1", w_en_cnt); end
    checks++; if (w_en_k != 9 + EN_K) begin errors++; $display("FAIL bounce_cycle: got %0d expected %0d", w_en_k, 9 + EN_K); end
  endtask

  task automatic test_stop_game();
    set_board_all(2'd2);
    bus.stop_game = 1'b1;
    sel_window(20, 6, -1, -1, 0);
    bus.stop_game = 1'b0;
    checks++; if (w_en_cnt != 0 || w_busy != 0) begin errors++; $display("FAIL stop_at_sel: got move %0d busy %0d expected 0 0", w_en_cnt, w_busy); end
    sel_window(20, 6, REJ_K, -1, 0);
    bus.stop_game = 1'b0;
    checks++; if (w_en_cnt != 0 || w_rej_cnt != 0) begin errors++; $display("FAIL stop_in_check: got move %0d reject %0d expected 0 0", w_en_cnt, w_rej_cnt); end
    checks++; if (w_busy != 1) begin errors++; $display("FAIL stop_in_check_busy: got %0d cycles expected 1", w_busy); end
  endtask

  task automatic test_reset_mid();
    set_board_all(2'd2);
    goto_cell(1, 2);
    sel_window(20, 6, -1, REJ_K, 0);
    mx = 0; my = 0;
    checks++; if (w_en_cnt != 0) begin errors++; $display("FAIL reset_mid_move: got %0d strobes expected 0", w_en_cnt); end
    checks++; if (r_en != 0 || r_mx != 3 || r_my != 3 || r_rej != 0 || r_busy != 0) begin errors++; $display("FAIL reset_mid_outputs: got en %0d xy (%0d,%0d) rej %0d busy %0d expected 0 (3,3) 0 0", r_en, r_mx, r_my, r_rej, r_busy); end
    checks++; if (r_cx != 0 || r_cy != 0) begin errors++; $display("FAIL reset_mid_cursor: got (%0d,%0d) expected (0,0)", r_cx, r_cy); end
  endtask

  task automatic test_hold_through_reset();
    int first_k, changes, prev_x;
    reset = 1'b1;
    btn_right = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    first_k = -1; changes = 0; prev_x = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (int'(cursor_x) != prev_x) begin
        changes++;
        if (first_k < 0) first_k = k;
        prev_x = int'(cursor_x);
      end
      tick();
    end
    btn_right = 1'b0;
    repeat (10) tick();
    mx = 1; my = 0;
    checks++; if (changes != 1 || prev_x != 1) begin errors++; $display("FAIL hold_reset_count: got %0d steps to x=%0d expected 1 step to x=1", changes, prev_x); end
    checks++; if (first_k != DB + 3) begin errors++; $display("FAIL hold_reset_delay: got %0d expected %0d", first_k, DB + 3); end
  endtask

  initial begin
    bus.board = '1;
    bus.stop_game = 1'b0;
    set_board_all(2'd2);
    test_reset();
    test_cursor();
    test_simultaneous();
    test_move_latency();
    test_reject();
    test_random_moves();
    test_bounce();
    test_stop_game();
    test_reset_mid();
    test_hold_through_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttt_move_ctrl.md
TTT_MOVE_CTRL -- requirements
Module: ttt_move_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required before a button level is accepted.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: cycles spent in WAIT after a move is issued.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 btn_up, btn_down, btn_left, btn_right, btn_sel  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 board  input  18  game board; cell (y,x) at bits 2*(3y+x)+:2; 2 = empty, 0/1 = player mark.
REQ-007 stop_game  input  1  game over; moves are locked out while high.
REQ-008 move_en  output  1  one-cycle move strobe to the game core's enable.
REQ-009 move_x, move_y  output  3 each  move coordinates; 3 whenever move_en is low.
REQ-010 cursor_x, cursor_y  output  2 each  current cursor position, range 0..2.
REQ-011 reject  output  1  one-cycle pulse when a selected cell is occupied.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level after DEBOUNCE_CYCLES consecutive equal samples.
REQ-014 A one-cycle press pulse SHALL fire in the cycle the debounced level goes 0->1; releases produce no pulse.
REQ-015 A raw level held from cycle t SHALL give a press pulse at cycle t+2+DEBOUNCE_CYCLES.
REQ-016 Right/left press SHALL increment/decrement cursor_x modulo 3 (2->0, 0->2); down/up SHALL do the same for cursor_y; this applies in every FSM state.
REQ-017 Up and down pressed in the same cycle SHALL leave cursor_y unchanged; likewise left and right for cursor_x; x and y moves in one cycle SHALL both apply.
REQ-018 FSM states SHALL be IDLE, CHECK, ISSUE, WAIT.
REQ-019 IDLE: a sel pulse with stop_game low SHALL latch the pre-update cursor as target and go to CHECK; a sel pulse with stop_game high SHALL be ignored.
REQ-020 CHECK: if stop_game is high, go to IDLE with no strobe; else if the target cell equals 2, go to ISSUE; otherwise pulse reject and go to IDLE.
REQ-021 ISSUE: move_en=1, move_x/move_y = target, zero-extended, for exactly one cycle; then go to WAIT.
REQ-022 WAIT: count SETTLE_CYCLES cycles, then go to IDLE; sel pulses arriving outside IDLE SHALL be dropped.
REQ-023 Latency: sel pulse at cycle E gives CHECK at E+1 and move_en at E+2, i.e. raw press t gives move_en at t+DEBOUNCE_CYCLES+4.
REQ-024 move_en SHALL never be high in two consecutive cycles, and never high while move_x or move_y is >= 3.
REQ-025 A board value of 3 SHALL be treated as occupied.

Reset
REQ-026 On reset: state IDLE, cursor (0,0), move_en 0, move_x/move_y 3, reject 0, busy 0, debounced levels 0, synchronizers and counters cleared.
REQ-027 Reset asserted mid-operation (CHECK/ISSUE/WAIT) SHALL abort with no move_en in the following cycle.
REQ-028 A button held through reset release SHALL produce one press pulse after the debounce delay.

Structure
REQ-029 Package ttt_pkg SHALL hold the FSM state enum, the constants CELL_EMPTY=2 and BOARD_DIM=3, and a cell-index helper function.
REQ-030 Sub-module ttt_btn_debounce (synchronizer + debouncer + edge detector, parameter DEBOUNCE_CYCLES) SHALL be instantiated five times.

Verification
REQ-031 Reset, then press right x4 and down x2 -> cursor (1,2) after each pulse settles; left at x=0 -> x=2.
REQ-032 Empty board, cursor (2,1), press sel at t -> move_en at t+8 (default params), move_x=2, move_y=1, single cycle, busy high for 4 cycles.
REQ-033 Board cell (0,0)=0, press sel at (0,0) -> reject pulse at E+1, no move_en.
REQ-034 Bounce: btn_sel toggling every cycle for 10 cycles, then stable high -> exactly one move_en.
REQ-035 stop_game=1 at sel, and stop_game rising during CHECK -> no move_en, FSM returns to IDLE.
REQ-036 Reset asserted in ISSUE's preceding cycle (CHECK) -> move_en stays 0, outputs at reset values.
